wt_mem_initiator: RTL

// - Memory-side initiator of the write-through cache: the requester end of the data-memory A/WD/WE/RD port.
// - Buffers write-through stores in a FIFO and drains them to data memory in order.
// - Runs block refills on read misses, returning one word per beat to the cache.
// - Sits between the cache controller and the data memory; the only block that drives the memory port.

---
 rtl/wt_mem_initiator_if.sv | 38 +++
 rtl/wt_mem_initiator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_initiator_if.sv
// Cache-side and memory-side signal bundle of the write-through memory initiator.
// master = the initiator itself; slave = cache controller plus data memory.
interface wt_mem_initiator_if #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int BLOCK_WORDS = 4
);
    localparam int BW = $clog2(BLOCK_WORDS);

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-1:0] miss_addr;
    logic          refill_valid;
    logic [BW-1:0] refill_idx;
    logic [DW-1:0] refill_data;
    logic          refill_done;
    logic          busy;
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_WD;
    logic          mem_WE;
    logic [DW-1:0] mem_RD;

    modport master (
        input  wr_valid, wr_addr, wr_data, miss_valid, miss_addr, mem_RD,
        output wr_ready, miss_ready, refill_valid, refill_idx, refill_data,
               refill_done, busy, mem_A, mem_WD, mem_WE
    );

    modport slave (
        output wr_valid, wr_addr, wr_data, miss_valid, miss_addr, mem_RD,
        input  wr_ready, miss_ready, refill_valid, refill_idx, refill_data,
               refill_done, busy, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/wt_mem_initiator.sv
// Write-through cache memory initiator: store buffer drain plus block refill on read miss.
// Optional PERF_CNT_EN adds wr_cnt/refill_cnt performance counters.
//
// state    | meaning
// S_IDLE   | no access; pick buffered store first, else pending refill
// S_WRITE  | driving FIFO head to memory, mem_WE in the last wait cycle
// S_REFILL | reading block word idx, one strobe per completed word
module wt_mem_initiator #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WBUF_DEPTH  = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_WAIT    = 0
) (
    input  logic CLK,
    input  logic RST,
    wt_mem_initiator_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [15:0] wr_cnt,
    output logic [15:0] refill_cnt
`endif
);
    localparam int BW = $clog2(BLOCK_WORDS);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REFILL} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [BW-1:0]    idx_q, idx_d, idx_inc;
    logic [AW-1:0]    mem_a_q, mem_a_d;
    logic [DW-1:0]    mem_wd_q, mem_wd_d;
    logic             mem_we_q, mem_we_d;
    logic             rv_q, rv_d;
    logic [BW-1:0]    ri_q, ri_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             pop, miss_clr, push, miss_acc, full;
    logic             miss_pend_q;
    logic [AW-BW-1:0] blk_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic [AW-1:0]    fifo_addr [WBUF_DEPTH];
    logic [DW-1:0]    fifo_data [WBUF_DEPTH];
    logic             unused_miss_low;

    assign unused_miss_low = ^bus.miss_addr[BW-1:0];

    assign full     = (count_q == (PW+1)'(WBUF_DEPTH));
    assign push     = bus.wr_valid & bus.wr_ready;
    assign miss_acc = bus.miss_valid & bus.miss_ready;
    assign idx_inc  = idx_q + BW'(1);

    assign bus.wr_ready     = !full && !miss_pend_q;
    assign bus.miss_ready   = !miss_pend_q;
    assign bus.busy         = (state_q != S_IDLE) || (count_q != '0) || miss_pend_q;
    assign bus.mem_A        = mem_a_q;
    assign bus.mem_WD       = mem_wd_q;
    assign bus.mem_WE       = mem_we_q;
    assign bus.refill_valid = rv_q;
    assign bus.refill_idx   = ri_q;
    assign bus.refill_data  = rdata_q;
    assign bus.refill_done  = done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            idx_q    <= '0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            mem_we_q <= 1'b0;
            rv_q     <= 1'b0;
            ri_q     <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            mem_we_q <= mem_we_d;
            rv_q     <= rv_d;
            ri_q     <= ri_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
        end
    end

    // Memory-port registers are loaded from next-state values so an access
    // appears on the port in the first cycle of its state.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        rv_d     = 1'b0;
        ri_d     = ri_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        miss_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d  = S_WRITE;
                    wait_d   = WW'(MEM_WAIT);
                    mem_a_d  = fifo_addr[rptr_q];
                    mem_wd_d = fifo_data[rptr_q];
                end else if (miss_pend_q) begin
                    state_d = S_REFILL;
                    wait_d  = WW'(MEM_WAIT);
                    idx_d   = '0;
                    mem_a_d = {blk_q, {BW{1'b0}}};
                end
            end
            S_WRITE: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WW'(1);
                end else begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_REFILL: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WW'(1);
                end else begin
                    rv_d    = 1'b1;
                    ri_d    = idx_q;
                    rdata_d = bus.mem_RD;
                    if (idx_q == LAST_IDX) begin
                        done_d   = 1'b1;
                        miss_clr = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d   = idx_inc;
                        wait_d  = WW'(MEM_WAIT);
                        mem_a_d = {blk_q, idx_inc};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        mem_we_d = (state_d == S_WRITE) && (wait_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            miss_pend_q <= 1'b0;
            blk_q       <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW+1)'(1);
            else if (!push && pop) count_q <= count_q - (PW+1)'(1);
            if (miss_acc) begin
                miss_pend_q <= 1'b1;
                blk_q       <= bus.miss_addr[AW-1:BW];
            end else if (miss_clr) begin
                miss_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wptr_q] <= bus.wr_addr;
            fifo_data[wptr_q] <= bus.wr_data;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_cnt     <= '0;
            refill_cnt <= '0;
        end else begin
            if (mem_we_q) wr_cnt     <= wr_cnt + 16'd1;
            if (done_q)   refill_cnt <= refill_cnt + 16'd1;
        end
    end
`endif
endmodule
